// File: rtl/fix_mult_arb_pkg.sv
// rtl/fix_mult_arb_pkg.sv - shared types, width helper and reset values for fix_mult_arb
package fix_mult_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam state_t RST_STATE = IDLE;

    function automatic int id_w(input int nreq);
        return (nreq <= 2) ? 1 : $clog2(nreq);
    endfunction

    function automatic int rst_last(input int nreq);
        return nreq - 1;
    endfunction

endpackage

// File: rtl/fix_mult.sv
// rtl/fix_mult.sv - sign-magnitude fixed-point multiplier, N bits with Q fractional bits
module fix_mult #(
    parameter int Q = 8,
    parameter int N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] c
);

    logic [2*N-3:0] prod;
    logic           unused_bits;

    assign prod = {{(N-1){1'b0}}, a[N-2:0]} * {{(N-1){1'b0}}, b[N-2:0]};
    assign c    = {a[N-1] ^ b[N-1], prod[N-2+Q:Q]};

    // Truncated product bits are intentionally discarded.
    assign unused_bits = ^{prod[2*N-3:N-1+Q], prod[Q-1:0]};

endmodule

// File: rtl/fix_mult_rr_grant.sv
// rtl/fix_mult_rr_grant.sv - round-robin grant picker; FIX_MULT_ARB_PRIO_EN gives requester 0 fixed priority
module fix_mult_rr_grant
    import fix_mult_arb_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int ID_W = id_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] last,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] idx,
    output logic            any
);

    logic [NREQ-1:0] masked;
    logic [ID_W-1:0] pos;

    always_comb begin
        grant  = '0;
        idx    = '0;
        any    = 1'b0;
        pos    = '0;
        masked = req;
`ifdef FIX_MULT_ARB_PRIO_EN
        if (req[0]) begin
            grant[0] = 1'b1;
            any      = 1'b1;
        end
        masked[0] = 1'b0;
`endif
        // Search starts just after the last winner and wraps.
        for (int k = 1; k <= NREQ; k++) begin
            pos = ID_W'((int'(last) + k) % NREQ);
            if (!any && masked[pos]) begin
                grant[pos] = 1'b1;
                idx        = pos;
                any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fix_mult_arb.sv
// rtl/fix_mult_arb.sv - one fix_mult shared by NREQ requesters; FIX_MULT_ARB_PRIO_EN selects requester-0 priority
module fix_mult_arb
    import fix_mult_arb_pkg::*;
#(
    parameter int Q    = 8,
    parameter int N    = 16,
    parameter int NREQ = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*N-1:0]       req_a,
    input  logic [NREQ*N-1:0]       req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [id_w(NREQ)-1:0]   rsp_id,
    output logic [N-1:0]            rsp_c,
    output logic                    busy
);

    localparam int ID_W = id_w(NREQ);

    state_t          state;
    state_t          state_nxt;
    logic [N-1:0]    a_q;
    logic [N-1:0]    b_q;
    logic [N-1:0]    sel_a;
    logic [N-1:0]    sel_b;
    logic [N-1:0]    mult_c;
    logic [ID_W-1:0] id_q;
    logic [ID_W-1:0] last;
    logic [ID_W-1:0] gnt_idx;
    logic [NREQ-1:0] gnt;
    logic            gnt_any;
    logic            take;

    fix_mult_rr_grant #(.NREQ(NREQ)) u_grant (
        .req   (req_valid),
        .last  (last),
        .grant (gnt),
        .idx   (gnt_idx),
        .any   (gnt_any)
    );

    fix_mult #(.Q(Q), .N(N)) u_mult (
        .a (a_q),
        .b (b_q),
        .c (mult_c)
    );

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_a = req_a[i*N +: N];
                sel_b = req_b[i*N +: N];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RST_STATE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        rsp_valid = 1'b0;
        busy      = (state != IDLE);
        take      = 1'b0;
        case (state)
            IDLE: begin
                // Gated by rst so no handshake is ever signalled while reset wins.
                if (!rst) begin
                    req_ready = gnt;
                end
                if (gnt_any) begin
                    take      = 1'b1;
                    state_nxt = MULT;
                end
            end
            MULT: begin
                state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            id_q   <= '0;
            last   <= ID_W'(rst_last(NREQ));
            rsp_c  <= '0;
            rsp_id <= '0;
        end else begin
            if (take) begin
                a_q  <= sel_a;
                b_q  <= sel_b;
                id_q <= gnt_idx;
`ifdef FIX_MULT_ARB_PRIO_EN
                if (gnt_idx != '0) begin
                    last <= gnt_idx;
                end
`else
                last <= gnt_idx;
`endif
            end
            if (state == MULT) begin
                rsp_c  <= mult_c;
                rsp_id <= id_q;
            end
        end
    end

endmodule

// File: tb/tb_fix_mult_arb.sv
// tb/tb_fix_mult_arb.sv - self-checking bench for fix_mult_arb with a behavioural arbiter/multiplier model
module tb_fix_mult_arb;

    localparam int Q    = 8;
    localparam int N    = 16;
    localparam int NREQ = 4;
`ifdef FIX_MULT_ARB_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      req_valid;
    logic [3:0]      req_ready;
    logic [63:0]     req_a;
    logic [63:0]     req_b;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [1:0]      rsp_id;
    logic [15:0]     rsp_c;
    logic            busy;

    int n_checks = 0;
    int n_fail   = 0;
    int last_m   = NREQ - 1;

    fix_mult_arb #(.Q(Q), .N(N), .NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_c     (rsp_c),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] fm(input logic [15:0] a, input logic [15:0] b);
        longint unsigned ma;
        longint unsigned mb;
        longint unsigned p;
        ma = longint'(a) & 64'h7fff;
        mb = longint'(b) & 64'h7fff;
        p  = (ma * mb) >> Q;
        return {a[15] ^ b[15], 15'(p & 64'h7fff)};
    endfunction

    function automatic int exp_winner(input logic [3:0] v, input int last);
        int i;
        if (PRIO && v[0]) return 0;
        for (int k = 1; k <= NREQ; k++) begin
            i = (last + k) % NREQ;
            if (PRIO && i == 0) continue;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic int next_last(input int w, input int last);
        if (PRIO && w == 0) return last;
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        req_a     = '0;
        req_b     = '0;
        tick();
        rst    = 1'b0;
        last_m = NREQ - 1;
    endtask

    task automatic drain();
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (6) tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 4'hf;
        req_a     = {$urandom, $urandom};
        req_b     = {$urandom, $urandom};
        tick();
        tick();
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        n_checks++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL reset_rsp_id: got %0d expected 0", rsp_id); end
        n_checks++; if (rsp_c !== 16'h0000) begin n_fail++; $display("FAIL reset_rsp_c: got %h expected 0000", rsp_c); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst       = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        last_m    = NREQ - 1;
    endtask

    task automatic test_basic();
        do_reset();
        req_a[15:0] = 16'h0200;
        req_b[15:0] = 16'h0180;
        req_valid   = 4'b0001;
        #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL basic_grant: got %b expected 0001", req_ready); end
        tick();
        last_m    = next_last(0, last_m);
        req_valid = '0;
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b expected 0", rsp_valid); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b expected 1", busy); end
        tick();
        n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL basic_rsp_valid: got %b expected 1", rsp_valid); end
        n_checks++; if (rsp_c !== 16'h0300) begin n_fail++; $display("FAIL basic_rsp_c: got %h expected 0300", rsp_c); end
        n_checks++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL basic_rsp_id: got %0d expected 0", rsp_id); end
        rsp_ready = 1'b1;
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle_after: got %b expected 0", busy); end
        rsp_ready = 1'b0;
    endtask

    task automatic test_round_robin();
        int k;
        int prev;
        int w;
        do_reset();
        req_a     = {$urandom, $urandom};
        req_b     = {$urandom, $urandom};
        req_valid = 4'hf;
        rsp_ready = 1'b1;
        k    = 0;
        prev = 0;
        for (int c = 0; c < 15; c++) begin
            #1;
            if (req_ready !== 4'b0000) begin
                w = exp_winner(4'hf, last_m);
                n_checks++; if (req_ready !== 4'(1 << w)) begin n_fail++; $display("FAIL rr_order[%0d]: got %b expected %b", k, req_ready, 4'(1 << w)); end
                if (k > 0) begin
                    n_checks++; if (c - prev != 3) begin n_fail++; $display("FAIL rr_spacing[%0d]: got %0d cycles expected 3", k, c - prev); end
                end
                last_m = next_last(w, last_m);
                prev   = c;
                k++;
            end
            tick();
        end
        n_checks++; if (k != 5) begin n_fail++; $display("FAIL rr_grant_count: got %0d expected 5", k); end
        drain();
    endtask

    task automatic test_stall();
        logic [15:0] a1;
        logic [15:0] b1;
        logic [15:0] exp_c;
        do_reset();
        a1 = 16'($urandom);
        b1 = 16'($urandom);
        req_a[31:16] = a1;
        req_b[31:16] = b1;
        exp_c        = fm(a1, b1);
        req_valid    = 4'b0010;
        #1;
        n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL stall_grant: got %b expected 0010", req_ready); end
        tick();
        req_valid = '0;
        tick();
        req_valid = 4'hf;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++; if (rsp_valid !== 1'b1 || rsp_c !== exp_c || rsp_id !== 2'd1) begin n_fail++; $display("FAIL stall_hold[%0d]: got v=%b c=%h id=%0d expected v=1 c=%h id=1", i, rsp_valid, rsp_c, rsp_id, exp_c); end
            n_checks++; if (busy !== 1'b1 || req_ready !== 4'b0000) begin n_fail++; $display("FAIL stall_no_grant[%0d]: got busy=%b ready=%b expected busy=1 ready=0000", i, busy, req_ready); end
            tick();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        tick();
        n_checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL stall_release: got busy=%b valid=%b expected 0 0", busy, rsp_valid); end
        rsp_ready = 1'b0;
        last_m    = 1;
    endtask

    task automatic test_reset_in_mult();
        int w;
        do_reset();
        req_a     = {$urandom, $urandom};
        req_b     = {$urandom, $urandom};
        req_valid = 4'b0010;
        #1;
        tick();
        req_valid = '0;
        rst       = 1'b1;
        rsp_ready = 1'b1;
        tick();
        rst    = 1'b0;
        last_m = NREQ - 1;
        n_checks++; if (req_ready !== 4'b0000 || rsp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmult_ctrl: got ready=%b valid=%b busy=%b expected 0000 0 0", req_ready, rsp_valid, busy); end
        n_checks++; if (rsp_c !== 16'h0000 || rsp_id !== 2'd0) begin n_fail++; $display("FAIL rstmult_data: got c=%h id=%0d expected 0000 0", rsp_c, rsp_id); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rstmult_discard[%0d]: got rsp_valid=%b expected 0", i, rsp_valid); end
            tick();
        end
        req_valid = 4'hf;
        #1;
        w = exp_winner(4'hf, last_m);
        n_checks++; if (req_ready !== 4'(1 << w)) begin n_fail++; $display("FAIL rstmult_next_grant: got %b expected %b", req_ready, 4'(1 << w)); end
        tick();
        last_m = next_last(w, last_m);
        drain();
    endtask

    task automatic test_withdraw();
        int seen;
        do_reset();
        req_a     = {$urandom, $urandom};
        req_b     = {$urandom, $urandom};
        req_valid = 4'b0001;
        #1;
        tick();
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        rsp_ready = 1'b1;
        seen      = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL withdraw_grant[%0d]: got %b expected 0000", i, req_ready); end
            if (rsp_valid === 1'b1) begin
                seen++;
                n_checks++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL withdraw_rsp_id: got %0d expected 0", rsp_id); end
            end
            tick();
        end
        n_checks++; if (seen != 1) begin n_fail++; $display("FAIL withdraw_rsp_count: got %0d expected 1", seen); end
        rsp_ready = 1'b0;
        last_m    = next_last(0, NREQ - 1);
    endtask

    task automatic test_random();
        logic [15:0] qc[$];
        int          qid[$];
        int          done;
        int          cycles;
        int          w;
        int          gw;
        bit          acc;
        logic [3:0]  exp_r;
        do_reset();
        done   = 0;
        cycles = 0;
        gw     = -1;
        acc    = 1'b0;
        while (done < 1000 && cycles < 20000) begin
            if (gw >= 0) req_valid[gw] = 1'b0;
            gw = -1;
            if (acc) begin
                void'(qc.pop_front());
                void'(qid.pop_front());
                acc = 1'b0;
                done++;
            end
            if (rsp_valid === 1'b1) begin
                if (qc.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL rand_spurious_rsp: got rsp_valid=1 with id=%0d expected no response", rsp_id);
                end else begin
                    n_checks++; if (rsp_c !== qc[0]) begin n_fail++; $display("FAIL rand_rsp_c[%0d]: got %h expected %h", done, rsp_c, qc[0]); end
                    n_checks++; if (int'(rsp_id) != qid[0]) begin n_fail++; $display("FAIL rand_rsp_id[%0d]: got %0d expected %0d", done, rsp_id, qid[0]); end
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            if (rsp_valid === 1'b1 && rsp_ready) acc = 1'b1;
            for (int i = 0; i < 2; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
                    req_a[i*16 +: 16] = 16'($urandom);
                    req_b[i*16 +: 16] = 16'($urandom);
                    req_valid[i]      = 1'b1;
                end
            end
            #1;
            w     = (qc.size() == 0) ? exp_winner(req_valid, last_m) : -1;
            exp_r = (w < 0) ? 4'b0000 : 4'(1 << w);
            n_checks++; if (req_ready !== exp_r) begin n_fail++; $display("FAIL rand_grant[cycle %0d]: got %b expected %b", cycles, req_ready, exp_r); end
            if (w >= 0) begin
                qc.push_back(fm(req_a[w*16 +: 16], req_b[w*16 +: 16]));
                qid.push_back(w);
                last_m = next_last(w, last_m);
                gw     = w;
            end
            tick();
            cycles++;
        end
        n_checks++; if (done != 1000) begin n_fail++; $display("FAIL rand_completed: got %0d expected 1000 within budget", done); end
        drain();
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        req_a     = '0;
        req_b     = '0;
        test_reset();
        test_basic();
        test_round_robin();
        test_stall();
        test_reset_in_mult();
        test_withdraw();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
